// File: rtl/objects_compositor.sv
// Layered bitmap compositor with player-collision detection.
// Picks the highest-priority requesting layer per pixel and tracks per-frame player overlaps.
module objects_compositor #(
  parameter int          NUM_LAYERS           = 4,
  parameter logic [7:0]  TRANSPARENT_ENCODING = 8'hFF
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [NUM_LAYERS-1:0]   drawingRequest,
  input  logic [8*NUM_LAYERS-1:0] layerRGB,
  input  logic [7:0]              backGroundRGB,
  output logic [7:0]              RGBOut,
  output logic                    collision,
  output logic [NUM_LAYERS-2:0]   collisionMask,
  output logic [7:0]              hitCount
);

  // Transparency is already folded into drawingRequest by the layer sources,
  // so the encoding only takes part in this elaboration-time sanity check.
  if (NUM_LAYERS < 2 || NUM_LAYERS > 8 || $bits(TRANSPARENT_ENCODING) != 8) begin : g_param_check
    $error("objects_compositor: NUM_LAYERS must be 2..8");
  end

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } frame_state_t;

  frame_state_t          state, state_next;
  logic [7:0]            rgb_next;
  logic                  collision_next;
  logic                  hit;
  logic [NUM_LAYERS-2:0] hit_bits;
  logic [NUM_LAYERS-2:0] accum;

  assign hit_bits = drawingRequest[NUM_LAYERS-1:1];
  assign hit      = drawingRequest[0] & (|hit_bits);

  // Scan from lowest priority upward so the lowest requesting index wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    rgb_next = backGroundRGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (drawingRequest[i]) rgb_next = layerRGB[8*i +: 8];
    end
  end

  // A hit coinciding with startOfFrame belongs to the new frame.
  always_comb begin
    state_next     = state;
    collision_next = 1'b0;
    if (startOfFrame) begin
      state_next     = hit ? FIRED : ARMED;
      collision_next = hit;
    end else if (hit) begin
      collision_next = (state == ARMED);
      state_next     = FIRED;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ARMED;
      RGBOut    <= 8'h00;
      collision <= 1'b0;
      hitCount  <= 8'd0;
    end else begin
      state     <= state_next;
      RGBOut    <= rgb_next;
      collision <= collision_next;
      if (collision_next && hitCount != 8'd255) hitCount <= hitCount + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      accum         <= '0;
      collisionMask <= '0;
    end else if (startOfFrame) begin
      collisionMask <= accum;
      accum         <= hit ? hit_bits : '0;
    end else if (hit) begin
      accum         <= accum | hit_bits;
    end
  end

endmodule

// File: tb/tb_objects_compositor.sv
// Directed self-checking bench for objects_compositor (NUM_LAYERS = 4).
module tb_objects_compositor;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [3:0]  drawingRequest;
  logic [31:0] layerRGB;
  logic [7:0]  backGroundRGB;
  logic [7:0]  RGBOut;
  logic        collision;
  logic [2:0]  collisionMask;
  logic [7:0]  hitCount;

  int total = 0;
  int bad   = 0;

  objects_compositor #(.NUM_LAYERS(4), .TRANSPARENT_ENCODING(8'hFF)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .drawingRequest (drawingRequest),
    .layerRGB       (layerRGB),
    .backGroundRGB  (backGroundRGB),
    .RGBOut         (RGBOut),
    .collision      (collision),
    .collisionMask  (collisionMask),
    .hitCount       (hitCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sof, input logic [3:0] req);
    startOfFrame   = sof;
    drawingRequest = req;
    step();
  endtask

  int pulses;
  int extra;

  initial begin
    resetN         = 1'b0;
    startOfFrame   = 1'b0;
    drawingRequest = 4'b0000;
    layerRGB       = {8'h44, 8'h33, 8'h22, 8'h11};
    backGroundRGB  = 8'h5A;
    #3;
    check("reset_rgb",  32'(RGBOut), 32'h00);
    check("reset_coll", 32'(collision), 32'h0);
    check("reset_mask", 32'(collisionMask), 32'h0);
    check("reset_hits", 32'(hitCount), 32'h0);
    step();
    step();
    resetN = 1'b1;

    // Priority mux
    drive(1'b0, 4'b0110);
    check("prio_0110", 32'(RGBOut), 32'h22);
    drive(1'b0, 4'b0000);
    check("background", 32'(RGBOut), 32'h5A);
    drive(1'b0, 4'b1000);
    check("prio_1000", 32'(RGBOut), 32'h44);
    check("no_hit_coll", 32'(collision), 32'h0);

    // Frame 0 is implicit; layer 0 wins even with the transparent colour
    layerRGB = {8'h44, 8'h33, 8'h22, 8'hFF};
    drive(1'b0, 4'b0011);
    check("f0_coll", 32'(collision), 32'h1);
    check("f0_hits", 32'(hitCount), 32'h1);
    check("transp_prio", 32'(RGBOut), 32'hFF);
    drive(1'b0, 4'b0000);
    check("f0_coll_drop", 32'(collision), 32'h0);

    // Five-cycle overlap yields a single pulse
    drive(1'b1, 4'b0000);
    check("f0_mask", 32'(collisionMask), 32'h1);
    drive(1'b0, 4'b0101);
    check("run_pulse", 32'(collision), 32'h1);
    check("run_hits", 32'(hitCount), 32'h2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0101);
      check("run_no_repeat", 32'(collision), 32'h0);
    end
    check("run_hits_hold", 32'(hitCount), 32'h2);

    // Hits by layers 1 and 3 in separate cycles
    drive(1'b1, 4'b0000);
    check("mask_run", 32'(collisionMask), 32'h2);
    drive(1'b0, 4'b0011);
    check("l1_pulse", 32'(collision), 32'h1);
    drive(1'b0, 4'b0000);
    drive(1'b0, 4'b1001);
    check("l3_no_pulse", 32'(collision), 32'h0);
    check("mask_hold", 32'(collisionMask), 32'h2);
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0000);
    check("mask_101", 32'(collisionMask), 32'h5);
    check("hits_3", 32'(hitCount), 32'h3);
    drive(1'b0, 4'b0000);
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0000);
    check("mask_000", 32'(collisionMask), 32'h0);

    // startOfFrame coincident with a hit while FIRED
    drive(1'b0, 4'b0101);
    check("pre_fire", 32'(collision), 32'h1);
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0011);
    check("sof_hit_pulse", 32'(collision), 32'h1);
    check("sof_hit_hits", 32'(hitCount), 32'h5);
    check("sof_hit_mask", 32'(collisionMask), 32'h2);
    drive(1'b0, 4'b0000);
    check("sof_hit_drop", 32'(collision), 32'h0);
    drive(1'b1, 4'b0000);
    check("sof_hit_accum", 32'(collisionMask), 32'h1);

    // Reach hitCount 7, then reset mid-frame in FIRED
    drive(1'b0, 4'b0011);
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0000);
    drive(1'b0, 4'b0011);
    drive(1'b0, 4'b0011);
    check("pre_rst_hits", 32'(hitCount), 32'h7);
    check("pre_rst_mask", 32'(collisionMask), 32'h1);
    #2 resetN = 1'b0;
    drawingRequest = 4'b0000;
    #1;
    check("mid_rst_rgb",  32'(RGBOut), 32'h00);
    check("mid_rst_coll", 32'(collision), 32'h0);
    check("mid_rst_mask", 32'(collisionMask), 32'h0);
    check("mid_rst_hits", 32'(hitCount), 32'h0);
    step();
    resetN = 1'b1;
    drive(1'b0, 4'b0011);
    check("post_rst_pulse", 32'(collision), 32'h1);
    check("post_rst_hits", 32'(hitCount), 32'h1);
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0000);
    check("post_rst_mask", 32'(collisionMask), 32'h1);

    // Saturation over 256 colliding frames
    pulses = 0;
    extra  = 0;
    for (int f = 0; f < 256; f++) begin
      drive(1'b0, 4'b0011);
      if (collision) pulses++;
      drive(1'b0, 4'b0101);
      if (collision) extra++;
      drive(1'b1, 4'b0000);
      if (collision) extra++;
    end
    check("sat_pulses", 32'(pulses), 32'd256);
    check("sat_extra", 32'(extra), 32'd0);
    check("sat_hits", 32'(hitCount), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
